fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: program counter value loaded on reset.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-low.
REQ-004 redirect_i  input  1  branch/jump redirect strobe from a later stage.
REQ-005 redirect_pc_i  input  32  redirect target; bits [1:0] ignored (treated as 0).
REQ-006 imem_req_o  output  1  instruction memory request (registered).
REQ-007 imem_addr_o  output  32  instruction memory address.
REQ-008 imem_ack_i  input  1  memory accepts the request; read data valid in the same cycle.
REQ-009 imem_rdata_i  input  32  instruction word, valid when imem_ack_i=1.
REQ-010 out_valid_o  output  1  head entry valid toward the IF/ID pipeline register.
REQ-011 out_ready_i  input  1  IF/ID register accepts the head entry this cycle.
REQ-012 address_o  output  32  PC of the head instruction.
REQ-013 instr_o  output  32  head instruction word.
REQ-014 pc_add4_o  output  32  head PC + 4.

Function
REQ-015 Internal state: pc_q (32), req_q (1), 2-entry FIFO of {pc, instr, pc+4}, count (0..2), mode RUN/DRAIN, tgt_q (32).
REQ-016 imem_req_o = req_q; imem_addr_o = pc_q; pc_q and imem_req_o stay stable while req_q=1 and imem_ack_i=0.
REQ-017 imem_ack_i is sampled only while imem_req_o=1; an ack with req low is ignored.
REQ-018 Push: in RUN, imem_ack_i=1 and redirect_i=0 -> enqueue {pc_q, imem_rdata_i, pc_q+4}; pc_q <= pc_q+4 (modulo 2^32).
REQ-019 Pop: out_valid_o=1 and out_ready_i=1 -> dequeue head; same-cycle push and pop are both honoured.
REQ-020 out_valid_o = (count != 0); address_o/instr_o/pc_add4_o show head entry, all zero when count=0.
REQ-021 Request issue in RUN: if req_q=1 and imem_ack_i=0, req_q stays 1; otherwise req_q <= 1 iff count after this edge's push/pop < 2.
REQ-022 Zero-wait memory with out_ready_i=1 sustains one instruction per cycle.
REQ-023 FIFO never overflows: a request is outstanding only when at least one slot will be free at ack.
REQ-024 Redirect in RUN with no outstanding request, or with imem_ack_i=1 the same cycle: count <= 0, ack data discarded, pc_q <= {redirect_pc_i[31:2],2'b00}, req_q <= 1, stay RUN.
REQ-025 Redirect in RUN with req_q=1 and imem_ack_i=0: count <= 0, tgt_q <= target, mode <= DRAIN; req_q and pc_q held.
REQ-026 DRAIN: out_valid_o=0; req_q held until ack; on ack data discarded, pc_q <= tgt_q, req_q <= 1, mode <= RUN.
REQ-027 Redirect during DRAIN updates tgt_q (latest wins); ack and redirect in the same DRAIN cycle -> pc_q <= new target, RUN.
REQ-028 Redirect takes priority over a same-cycle pop; popped entry is still considered consumed by IF/ID, then flushed.

Reset
REQ-029 rst_i=0 asynchronously forces pc_q=RESET_PC, req_q=0, count=0, mode=RUN, tgt_q=0; all outputs 0.
REQ-030 First rising edge with rst_i=1 sets req_q=1 (first fetch at RESET_PC); reset mid-request abandons it without waiting for ack.

Verification
REQ-031 Reset release, zero-wait memory, out_ready_i=1 -> addresses 0x0,0x4,0x8 on consecutive cycles; out entries {0x0,instr,0x4}... one per cycle.
REQ-032 out_ready_i=0, zero-wait memory -> two entries (0x0,0x4) queued, imem_req_o drops, out_valid_o held with address_o=0x0; release -> 0x0,0x4,0x8 in order.
REQ-033 Memory ack delayed 3 cycles -> imem_req_o and imem_addr_o=0x8 constant for 3 cycles, entry 0x8 appears after ack.
REQ-034 Redirect to 0x103 with request at 0x10 outstanding -> queue flushed, DRAIN until ack, ack data dropped, next request at 0x100.
REQ-035 Redirect to 0x200 same cycle as ack -> ack data dropped, next cycle imem_addr_o=0x200, out_valid_o=0.
REQ-036 rst_i asserted mid-wait -> all outputs 0 immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, a 2-entry output queue
// toward IF/ID, and redirect handling that drains an in-flight request before refetching.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] address_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_add4_o
);

   typedef enum logic {RUN, DRAIN} mode_e;

   mode_e       mode_q, mode_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        req_q, req_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        hd_q, hd_d;

   logic [31:0] ent_pc_q  [2];
   logic [31:0] ent_ins_q [2];
   logic [31:0] ent_nx_q  [2];

   logic        ack;
   logic        pop;
   logic        push;
   logic        wr_idx;
   logic [31:0] target;

   assign ack    = req_q & imem_ack_i;
   assign pop    = (cnt_q != 2'd0) & out_ready_i;
   assign target = {redirect_pc_i[31:2], 2'b00};
   assign wr_idx = hd_q ^ cnt_q[0];

   always_comb begin
      mode_d = mode_q;
      pc_d   = pc_q;
      tgt_d  = tgt_q;
      req_d  = req_q;
      cnt_d  = cnt_q;
      hd_d   = hd_q;
      push   = 1'b0;
      case (mode_q)
         RUN: begin
            if (redirect_i) begin
               cnt_d = 2'd0;
               if (!req_q || ack) begin
                  pc_d  = target;
                  req_d = 1'b1;
               end else begin
                  tgt_d  = target;
                  mode_d = DRAIN;
               end
            end else begin
               push  = ack;
               cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
               hd_d  = pop ? ~hd_q : hd_q;
               if (ack) pc_d = pc_q + 32'd4;
               // An unanswered request must stay up; a new one is issued only while a slot is free.
               req_d = (req_q && !ack) || (cnt_d != 2'd2);
            end
         end
         DRAIN: begin
            if (ack) begin
               pc_d   = redirect_i ? target : tgt_q;
               req_d  = 1'b1;
               mode_d = RUN;
            end else if (redirect_i) begin
               tgt_d = target;
            end
         end
         default: mode_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mode_q <= RUN;
         pc_q   <= RESET_PC;
         tgt_q  <= 32'd0;
         req_q  <= 1'b0;
         cnt_q  <= 2'd0;
         hd_q   <= 1'b0;
      end else begin
         mode_q <= mode_d;
         pc_q   <= pc_d;
         tgt_q  <= tgt_d;
         req_q  <= req_d;
         cnt_q  <= cnt_d;
         hd_q   <= hd_d;
      end
   end

   // Queue payload carries no reset; validity is tracked solely by cnt_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         ent_pc_q[wr_idx]  <= pc_q;
         ent_ins_q[wr_idx] <= imem_rdata_i;
         ent_nx_q[wr_idx]  <= pc_q + 32'd4;
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = pc_q;
   assign out_valid_o = (cnt_q != 2'd0);
   assign address_o   = out_valid_o ? ent_pc_q[hd_q]  : 32'd0;
   assign instr_o     = out_valid_o ? ent_ins_q[hd_q] : 32'd0;
   assign pc_add4_o   = out_valid_o ? ent_nx_q[hd_q]  : 32'd0;

endmodule
